mips_mem_arbiter: RTL and testbench

MIPS_MEM_ARBITER -- requirements
Module: mips_mem_arbiter

---
 rtl/mips_pkg.sv | 7 +
 rtl/mips_mem_arbiter_if.sv | 36 +++
 rtl/mips_arb_prio.sv | 16 +
 rtl/mips_mem_arbiter.sv | 48 ++++
 tb/tb_mips_mem_arbiter.sv | 138 +++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared state encoding and default sizes for the MIPS memory arbiter
package mips_pkg;
  typedef enum logic [1:0] {IDLE, RD_I, RD_D} state_t;
  localparam int AW_DEF = 8;
  localparam int DW_DEF = 32;
  localparam int STARVE_MAX_DEF = 2;
endpackage

// File: rtl/mips_mem_arbiter_if.sv
// mips_mem_arbiter_if: fetch/data request ports plus single-port memory command bus
interface mips_mem_arbiter_if import mips_pkg::*; #(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);
  logic if_req;
  logic [AW-1:0] if_addr;
  logic if_gnt;
  logic if_rvalid;
  logic [DW-1:0] if_rdata;
  logic d_req;
  logic d_we;
  logic [3:0] d_be;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic d_gnt;
  logic d_rvalid;
  logic [DW-1:0] d_rdata;
  logic stall;
  logic mem_en;
  logic mem_we;
  logic [3:0] mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  modport master (
    output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
    input if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, stall,
    input mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );
  modport slave (
    input if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, stall,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mips_arb_prio.sv
// mips_arb_prio: data-over-fetch priority with anti-starvation override at streak limit
module mips_arb_prio #(
  parameter int STARVE_MAX = 2,
  parameter int SW = 2
) (
  input  logic ifReq,
  input  logic dReq,
  input  logic [SW-1:0] streak,
  output logic ifWin,
  output logic dWin
);
  always_comb begin
    dWin = dReq & ~(ifReq & (streak == SW'(STARVE_MAX)));
    ifWin = ifReq & ~dWin;
  end
endmodule

// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter: shares one single-port memory between instruction fetch and load/store
module mips_mem_arbiter import mips_pkg::*; #(
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input logic clock,
  input logic reset_n,
  mips_mem_arbiter_if.slave bus
);
  localparam int SW = STARVE_MAX > 0 ? $clog2(STARVE_MAX + 1) : 1;
  state_t state;
  logic [SW-1:0] streak;
  logic winI, winD, gntI, gntD;
  mips_arb_prio #(.STARVE_MAX(STARVE_MAX), .SW(SW)) prio (
    .ifReq(bus.if_req),
    .dReq(bus.d_req),
    .streak(streak),
    .ifWin(winI),
    .dWin(winD)
  );
  // Grants are masked during reset so every output reads zero while reset_n is low
  always_comb begin
    gntI = reset_n & winI;
    gntD = reset_n & winD;
    bus.if_gnt = gntI;
    bus.d_gnt = gntD;
    bus.stall = reset_n & ((bus.if_req & ~gntI) | (bus.d_req & ~gntD));
    bus.mem_en = gntI | gntD;
    bus.mem_we = gntD & bus.d_we;
    bus.mem_be = gntD ? bus.d_be : {4{gntI}};
    bus.mem_addr = gntD ? bus.d_addr : gntI ? bus.if_addr : {AW{1'b0}};
    bus.mem_wdata = gntD ? bus.d_wdata : {DW{1'b0}};
    bus.if_rvalid = state == RD_I;
    bus.d_rvalid = state == RD_D;
    bus.if_rdata = bus.if_rvalid ? bus.mem_rdata : {DW{1'b0}};
    bus.d_rdata = bus.d_rvalid ? bus.mem_rdata : {DW{1'b0}};
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      streak <= '0;
    end else begin
      state <= gntI ? RD_I : (gntD & ~bus.d_we) ? RD_D : IDLE;
      streak <= (!bus.if_req || gntI) ? '0 : (gntD && streak != SW'(STARVE_MAX)) ? streak + 1'b1 : streak;
    end
  end
endmodule

// File: tb/tb_mips_mem_arbiter.sv
// tb_mips_mem_arbiter: vector table plus read-return scoreboard for the memory arbiter
module tb_mips_mem_arbiter;
  import mips_pkg::*;
  typedef struct {
    logic ir; logic [7:0] ia; logic dr; logic we; logic [3:0] be; logic [7:0] da; logic [31:0] wd;
    logic eig; logic edg; logic est; logic een; logic ewe; logic [3:0] ebe; logic [7:0] ead; logic [31:0] ewd;
  } vec_t;
  typedef struct { logic isI; logic [31:0] data; } rsp_t;
  logic clock = 0;
  logic reset_n = 0;
  logic [31:0] mem [256];
  int nVec = 0;
  int nBad = 0;
  vec_t tbl [$];
  rsp_t sbQ [$];
  mips_mem_arbiter_if #(.AW(8), .DW(32)) bus ();
  mips_mem_arbiter #(.STARVE_MAX(2), .AW(8), .DW(32)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));
  always #5 clock = ~clock;
  always @(posedge clock) begin
    if (bus.mem_en && bus.mem_we) begin
      for (int b = 0; b < 4; b++) if (bus.mem_be[b]) mem[bus.mem_addr][8*b +: 8] = bus.mem_wdata[8*b +: 8];
    end else if (bus.mem_en) bus.mem_rdata <= mem[bus.mem_addr];
  end
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    nVec++;
    if (a !== e) begin
      nBad++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask
  function automatic vec_t mk(logic ir, logic [7:0] ia, logic dr, logic we, logic [3:0] be, logic [7:0] da, logic [31:0] wd, logic gi, logic gd, logic st);
    vec_t v;
    v.ir = ir; v.ia = ia; v.dr = dr; v.we = we; v.be = be; v.da = da; v.wd = wd;
    v.eig = gi; v.edg = gd; v.est = st; v.een = gi | gd; v.ewe = gd & we;
    v.ebe = gd ? be : gi ? 4'hF : 4'h0;
    v.ead = gd ? da : gi ? ia : 8'h00;
    v.ewd = gd ? wd : 32'h0;
    return v;
  endfunction
  function automatic vec_t idle(); return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endfunction
  function automatic vec_t fetch(logic [7:0] a); return mk(1, a, 0, 0, 0, 0, 0, 1, 0, 0); endfunction
  function automatic vec_t load(logic [7:0] a); return mk(0, 0, 1, 0, 4'hF, a, 0, 0, 1, 0); endfunction
  function automatic vec_t store(logic [7:0] a, logic [3:0] be, logic [31:0] wd); return mk(0, 0, 1, 1, be, a, wd, 0, 1, 0); endfunction
  function automatic vec_t both(logic gi); return mk(1, 8'h20, 1, 0, 4'hF, 8'h30, 0, gi, ~gi, 1); endfunction
  task automatic drive(vec_t v);
    bus.if_req = v.ir; bus.if_addr = v.ia; bus.d_req = v.dr; bus.d_we = v.we;
    bus.d_be = v.be; bus.d_addr = v.da; bus.d_wdata = v.wd;
  endtask
  task automatic checkRsp();
    rsp_t e;
    logic iv, dv;
    iv = 0; dv = 0; e.data = 0;
    if (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      iv = e.isI; dv = ~e.isI;
    end
    chk("if_rvalid", 32'(bus.if_rvalid), 32'(iv));
    chk("if_rdata", bus.if_rdata, iv ? e.data : 32'h0);
    chk("d_rvalid", 32'(bus.d_rvalid), 32'(dv));
    chk("d_rdata", bus.d_rdata, dv ? e.data : 32'h0);
  endtask
  task automatic step(vec_t v);
    @(posedge clock);
    #1 drive(v);
    @(negedge clock);
    checkRsp();
    chk("if_gnt", 32'(bus.if_gnt), 32'(v.eig));
    chk("d_gnt", 32'(bus.d_gnt), 32'(v.edg));
    chk("stall", 32'(bus.stall), 32'(v.est));
    chk("mem_en", 32'(bus.mem_en), 32'(v.een));
    chk("mem_we", 32'(bus.mem_we), 32'(v.ewe));
    chk("mem_be", 32'(bus.mem_be), 32'(v.ebe));
    chk("mem_addr", 32'(bus.mem_addr), 32'(v.ead));
    chk("mem_wdata", bus.mem_wdata, v.ewd);
    if (v.eig) sbQ.push_back('{1'b1, mem[v.ia]});
    else if (v.edg && !v.we) sbQ.push_back('{1'b0, mem[v.da]});
  endtask
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {8'(i), ~8'(i), 8'(i) ^ 8'h3C, 8'hC3};
    mem[8'h10] = 32'hDEADBEEF;
    bus.mem_rdata = 0;
    drive(mk(1, 8'h11, 1, 0, 4'hF, 8'h22, 0, 0, 0, 0));
    repeat (2) @(negedge clock);
    chk("rst if_gnt", 32'(bus.if_gnt), 0);
    chk("rst d_gnt", 32'(bus.d_gnt), 0);
    chk("rst stall", 32'(bus.stall), 0);
    chk("rst mem_en", 32'(bus.mem_en), 0);
    chk("rst mem_addr", 32'(bus.mem_addr), 0);
    chk("rst if_rvalid", 32'(bus.if_rvalid), 0);
    chk("rst d_rvalid", 32'(bus.d_rvalid), 0);
    drive(idle());
    reset_n = 1;
    tbl.push_back(idle());
    tbl.push_back(fetch(8'h10));
    tbl.push_back(idle());
    tbl.push_back(store(8'h05, 4'b0011, 32'h0000ABCD));
    tbl.push_back(idle());
    tbl.push_back(load(8'h01));
    tbl.push_back(fetch(8'h02));
    tbl.push_back(idle());
    for (int i = 0; i < 6; i++) tbl.push_back(both(i % 3 == 2));
    tbl.push_back(idle());
    tbl.push_back(store(8'h07, 4'h0, 32'hFFFFFFFF));
    tbl.push_back(load(8'h07));
    tbl.push_back(store(8'h07, 4'hF, 32'h12345678));
    tbl.push_back(load(8'h07));
    tbl.push_back(load(8'h05));
    tbl.push_back(idle());
    tbl.push_back(both(0));
    tbl.push_back(load(8'h30));
    tbl.push_back(both(0));
    tbl.push_back(both(0));
    tbl.push_back(both(1));
    tbl.push_back(idle());
    foreach (tbl[i]) step(tbl[i]);
    chk("idle streak", 32'(dut.streak), 0);
    chk("mem[7] after stores", mem[8'h07], 32'h12345678);
    chk("mem[5] byte store", mem[8'h05], {8'h05, 8'hFA, 8'hAB, 8'hCD});
    step(load(8'h03));
    @(posedge clock);
    #1 reset_n = 0;
    drive(load(8'h04));
    @(negedge clock);
    chk("mid-rst d_rvalid", 32'(bus.d_rvalid), 0);
    chk("mid-rst d_rdata", bus.d_rdata, 0);
    chk("mid-rst d_gnt", 32'(bus.d_gnt), 0);
    chk("mid-rst state", 32'(dut.state), 32'(IDLE));
    chk("mid-rst streak", 32'(dut.streak), 0);
    sbQ.delete();
    drive(idle());
    #2 reset_n = 1;
    step(fetch(8'h04));
    step(idle());
    step(idle());
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end
endmodule
